// File: rtl/nes_clk_rst_seq.sv
// Start-up sequencer for the NES clock-enable domains, all on the master clock.
// Latency: every output is a register; a cause sampled at one edge shows on the outputs after that edge.
// Backpressure: none. Lock loss beats soft_rst, which beats a finishing hold count.
//
// Ports:
//   clk_mst      master clock, sole clock
//   rst_mst      synchronous active-low reset
//   mmcm_locked  MMCM lock, synchronous to clk_mst
//   soft_rst     one-cycle pulse, restarts the sequence from ALIGN
//   clk_en_cpu   one-cycle CPU enable every CPU_CLK_DIV cycles
//   clk_en_ppu   one-cycle PPU enable every PPU_CLK_DIV cycles
//   rst_en_cpu   active-high CPU domain reset
//   rst_en_ppu   active-high PPU domain reset
//   seq_ready    high only in RUN
//   seq_state    current state encoding, for debug
module nes_clk_rst_seq #(
  parameter int CPU_CLK_DIV  = 12,
  parameter int PPU_CLK_DIV  = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int PPU_RST_HOLD = 8,
  parameter int CPU_RST_HOLD = 8
) (
  input  logic       clk_mst,
  input  logic       rst_mst,
  input  logic       mmcm_locked,
  input  logic       soft_rst,
  output logic       clk_en_cpu,
  output logic       clk_en_ppu,
  output logic       rst_en_cpu,
  output logic       rst_en_ppu,
  output logic       seq_ready,
  output logic [2:0] seq_state
);

  if (CPU_CLK_DIV < 2 || CPU_CLK_DIV > 32) begin : g_bad_cpu_div
    $error("CPU_CLK_DIV out of range 2..32");
  end
  if (PPU_CLK_DIV < 2 || PPU_CLK_DIV > 32) begin : g_bad_ppu_div
    $error("PPU_CLK_DIV out of range 2..32");
  end
  if (LOCK_STABLE < 1 || LOCK_STABLE > 255) begin : g_bad_lock
    $error("LOCK_STABLE out of range 1..255");
  end
  if (PPU_RST_HOLD < 1 || PPU_RST_HOLD > 255) begin : g_bad_ppu_hold
    $error("PPU_RST_HOLD out of range 1..255");
  end
  if (CPU_RST_HOLD < 1 || CPU_RST_HOLD > 255) begin : g_bad_cpu_hold
    $error("CPU_RST_HOLD out of range 1..255");
  end

  localparam int CW  = $clog2(CPU_CLK_DIV);
  localparam int PW  = $clog2(PPU_CLK_DIV);
  localparam int LW  = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int PHW = $clog2(PPU_RST_HOLD + 1);
  localparam int CHW = $clog2(CPU_RST_HOLD + 1);

  localparam logic [CW-1:0]  CPU_DIV_LAST  = CW'(CPU_CLK_DIV - 1);
  localparam logic [PW-1:0]  PPU_DIV_LAST  = PW'(PPU_CLK_DIV - 1);
  localparam logic [LW-1:0]  LOCK_LAST     = LW'(LOCK_STABLE - 1);
  localparam logic [PHW-1:0] PPU_HOLD_MAX  = PHW'(PPU_RST_HOLD);
  localparam logic [PHW-1:0] PPU_HOLD_LAST = PHW'(PPU_RST_HOLD - 1);
  localparam logic [CHW-1:0] CPU_HOLD_MAX  = CHW'(CPU_RST_HOLD);
  localparam logic [CHW-1:0] CPU_HOLD_LAST = CHW'(CPU_RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_ALIGN     = 3'd2,
    S_PPU_RST   = 3'd3,
    S_CPU_RST   = 3'd4,
    S_RUN       = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]    cpu_div_q, cpu_div_d;
  logic [PW-1:0]    ppu_div_q, ppu_div_d;
  logic [PHW-1:0]   ppu_hold_q, ppu_hold_d;
  logic [CHW-1:0]   cpu_hold_q, cpu_hold_d;
  logic             en_cpu_q, en_cpu_d;
  logic             en_ppu_q, en_ppu_d;
  logic             rst_cpu_q, rst_cpu_d;
  logic             rst_ppu_q, rst_ppu_d;
  logic             ready_q, ready_d;
  logic             running_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (mmcm_locked && lock_cnt_q == LOCK_LAST) state_d = S_ALIGN;
      S_ALIGN:     state_d = S_PPU_RST;
      // Hold counters count pulses already seen, so the last pulse is
      // recognised while it is on the output and the next edge moves on.
      S_PPU_RST:   if (en_ppu_q && ppu_hold_q == PPU_HOLD_LAST) state_d = S_CPU_RST;
      S_CPU_RST:   if (en_cpu_q && cpu_hold_q == CPU_HOLD_LAST) state_d = S_RUN;
      S_RUN:       state_d = S_RUN;
      default:     state_d = S_IDLE;
    endcase
    // Lock loss overrides soft reset, which overrides hold completion.
    if (state_q == S_ALIGN || state_q == S_PPU_RST ||
        state_q == S_CPU_RST || state_q == S_RUN) begin
      if (!mmcm_locked) begin
        state_d = S_WAIT_LOCK;
      end else if (soft_rst && state_q != S_ALIGN) begin
        state_d = S_ALIGN;
      end
    end
  end

  always_comb begin
    running_d = (state_d == S_PPU_RST) || (state_d == S_CPU_RST) || (state_d == S_RUN);

    lock_cnt_d = '0;
    if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && mmcm_locked) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    // Dividers sit at 0 outside the running states, so leaving ALIGN both
    // enables fire together and then stay phase-locked.
    cpu_div_d = '0;
    ppu_div_d = '0;
    en_cpu_d  = 1'b0;
    en_ppu_d  = 1'b0;
    if (running_d) begin
      cpu_div_d = (cpu_div_q == CPU_DIV_LAST) ? '0 : cpu_div_q + 1'b1;
      ppu_div_d = (ppu_div_q == PPU_DIV_LAST) ? '0 : ppu_div_q + 1'b1;
      en_cpu_d  = (cpu_div_q == '0);
      en_ppu_d  = (ppu_div_q == '0);
    end

    ppu_hold_d = '0;
    if (state_d == S_PPU_RST) begin
      ppu_hold_d = ppu_hold_q;
      if (en_ppu_q && ppu_hold_q != PPU_HOLD_MAX) ppu_hold_d = ppu_hold_q + 1'b1;
    end
    cpu_hold_d = '0;
    if (state_d == S_CPU_RST) begin
      cpu_hold_d = cpu_hold_q;
      if (en_cpu_q && cpu_hold_q != CPU_HOLD_MAX) cpu_hold_d = cpu_hold_q + 1'b1;
    end

    rst_ppu_d = !((state_d == S_CPU_RST) || (state_d == S_RUN));
    rst_cpu_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk_mst) begin
    if (!rst_mst) begin
      state_q    <= S_IDLE;
      lock_cnt_q <= '0;
      cpu_div_q  <= '0;
      ppu_div_q  <= '0;
      ppu_hold_q <= '0;
      cpu_hold_q <= '0;
      en_cpu_q   <= 1'b0;
      en_ppu_q   <= 1'b0;
      rst_cpu_q  <= 1'b1;
      rst_ppu_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      cpu_div_q  <= cpu_div_d;
      ppu_div_q  <= ppu_div_d;
      ppu_hold_q <= ppu_hold_d;
      cpu_hold_q <= cpu_hold_d;
      en_cpu_q   <= en_cpu_d;
      en_ppu_q   <= en_ppu_d;
      rst_cpu_q  <= rst_cpu_d;
      rst_ppu_q  <= rst_ppu_d;
      ready_q    <= ready_d;
    end
  end

  assign clk_en_cpu = en_cpu_q;
  assign clk_en_ppu = en_ppu_q;
  assign rst_en_cpu = rst_cpu_q;
  assign rst_en_ppu = rst_ppu_q;
  assign seq_ready  = ready_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_nes_clk_rst_seq.sv
// Bench for nes_clk_rst_seq: default instance (CPU 12 / PPU 4) and a CPU 12 / PPU 5 instance.
// The model tracks the sequence by timestamps and derives expected outputs arithmetically.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_nes_clk_rst_seq;

  logic clk_mst = 1'b0;
  logic rst_mst, mmcm_locked, soft_rst;
  logic [1:0] ecpu, eppu, rcpu, rppu, rdy;
  logic [2:0] st0, st1;

  always #5 clk_mst = ~clk_mst;

  nes_clk_rst_seq u_dut0 (
    .clk_mst(clk_mst), .rst_mst(rst_mst), .mmcm_locked(mmcm_locked), .soft_rst(soft_rst),
    .clk_en_cpu(ecpu[0]), .clk_en_ppu(eppu[0]), .rst_en_cpu(rcpu[0]), .rst_en_ppu(rppu[0]),
    .seq_ready(rdy[0]), .seq_state(st0));

  nes_clk_rst_seq #(.CPU_CLK_DIV(12), .PPU_CLK_DIV(5)) u_dut1 (
    .clk_mst(clk_mst), .rst_mst(rst_mst), .mmcm_locked(mmcm_locked), .soft_rst(soft_rst),
    .clk_en_cpu(ecpu[1]), .clk_en_ppu(eppu[1]), .rst_en_cpu(rcpu[1]), .rst_en_ppu(rppu[1]),
    .seq_ready(rdy[1]), .seq_state(st1));

  // Model: mode of the sequence plus the edge number at which ALIGN was entered.
  localparam int M_IDLE = 0, M_WAIT = 1, M_ALIGN = 2, M_SEQ = 3;
  localparam int LOCK_N = 16, HOLD = 8, CDIV = 12;
  int cyc = 0;
  int m_mode = M_IDLE;
  int m_run = 0;
  int m_align = 0;

  always @(posedge clk_mst) begin
    cyc++;
    if (!rst_mst) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_WAIT; m_run = 0; end
        M_WAIT: begin
          if (mmcm_locked) begin
            m_run++;
            if (m_run == LOCK_N) begin m_mode = M_ALIGN; m_align = cyc; end
          end else m_run = 0;
        end
        default: begin
          if (!mmcm_locked) begin m_mode = M_WAIT; m_run = 0; end
          else if (soft_rst && m_mode == M_SEQ) begin m_mode = M_ALIGN; m_align = cyc; end
          else if (m_mode == M_ALIGN) m_mode = M_SEQ;
        end
      endcase
    end
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int tstart = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Expected outputs for an instance with PPU divider p.
  task automatic compare_one(input int k, input int p);
    int d, dp, k0, dr, x_st, x_ec, x_ep, x_rc, x_rp, x_rdy;
    int a_st;
    x_ec = 0; x_ep = 0; x_rc = 1; x_rp = 1; x_rdy = 0; x_st = m_mode;
    if (m_mode == M_SEQ) begin
      d  = cyc - m_align;
      dp = 2 + (HOLD - 1) * p;
      k0 = (dp - 1 + CDIV - 1) / CDIV;
      dr = 2 + (k0 + HOLD - 1) * CDIV;
      x_ep = ((d - 1) % p == 0) ? 1 : 0;
      x_ec = ((d - 1) % CDIV == 0) ? 1 : 0;
      if (d < dp) x_st = 3;
      else if (d < dr) begin x_st = 4; x_rp = 0; end
      else begin x_st = 5; x_rp = 0; x_rc = 0; x_rdy = 1; end
    end
    a_st = (k == 0) ? int'(st0) : int'(st1);
    chk($sformatf("model_state[%0d]", k), a_st, x_st);
    chk($sformatf("model_en_cpu[%0d]", k), int'(ecpu[k]), x_ec);
    chk($sformatf("model_en_ppu[%0d]", k), int'(eppu[k]), x_ep);
    chk($sformatf("model_rst_cpu[%0d]", k), int'(rcpu[k]), x_rc);
    chk($sformatf("model_rst_ppu[%0d]", k), int'(rppu[k]), x_rp);
    chk($sformatf("model_ready[%0d]", k), int'(rdy[k]), x_rdy);
  endtask

  task automatic tick();
    @(negedge clk_mst);
    if (chk_en) begin
      compare_one(0, 4);
      compare_one(1, 5);
    end
  endtask

  // Waits for a dut0 output to take a value; t is cycles since tstart, -1 on timeout.
  // sel: 0 state, 1 en_ppu, 2 en_cpu, 3 rst_ppu, 4 ready
  task automatic wait_sig(input int sel, input int val, input int bound, output int t);
    int v;
    t = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      case (sel)
        0: v = int'(st0);
        1: v = int'(eppu[0]);
        2: v = int'(ecpu[0]);
        3: v = int'(rppu[0]);
        default: v = int'(rdy[0]);
      endcase
      if (v == val) begin t = cyc - tstart; break; end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(st0), 0);
    chk({tag, "_en_cpu"}, int'(ecpu[0]), 0);
    chk({tag, "_en_ppu"}, int'(eppu[0]), 0);
    chk({tag, "_rst_cpu"}, int'(rcpu[0]), 1);
    chk({tag, "_rst_ppu"}, int'(rppu[0]), 1);
    chk({tag, "_ready"}, int'(rdy[0]), 0);
  endtask

  initial begin
    int t, last, ncoinc;
    rst_mst = 1'b0; mmcm_locked = 1'b1; soft_rst = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    chk_reset_vals("reset");

    // Start-up timeline from reset release.
    rst_mst = 1'b1;
    tstart = cyc;
    wait_sig(0, 2, 40, t);  chk("align_time", t, 17);
    wait_sig(1, 1, 5, t);   chk("first_ppu_time", t, 18);
    chk("first_cpu_with_ppu", int'(ecpu[0]), 1);
    chk("dut1_first_coincident", int'(ecpu[1] & eppu[1]), 1);
    wait_sig(1, 1, 10, t);  chk("second_ppu_time", t, 22);
    wait_sig(2, 1, 20, t);  chk("second_cpu_time", t, 30);
    wait_sig(3, 0, 40, t);  chk("ppu_release_time", t, 47);
    wait_sig(4, 1, 150, t); chk("ready_time", t, 139);
    chk("dut1_ready", int'(rdy[1]), 1);

    // CPU 12 / PPU 5 coincidences over 1000 cycles of RUN.
    last = -1; ncoinc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ecpu[1] && eppu[1]) begin
        if (last >= 0) chk("coinc_interval", cyc - last, 60);
        last = cyc;
        ncoinc++;
      end
    end
    chk("coinc_count_ge16", (ncoinc >= 16) ? 1 : 0, 1);

    // Lock loss in RUN.
    mmcm_locked = 1'b0;
    tick();
    chk("lockloss_state", int'(st0), 1);
    chk("lockloss_en_cpu", int'(ecpu[0]), 0);
    chk("lockloss_en_ppu", int'(eppu[0]), 0);
    chk("lockloss_rst_cpu", int'(rcpu[0]), 1);
    chk("lockloss_rst_ppu", int'(rppu[0]), 1);
    chk("lockloss_ready", int'(rdy[0]), 0);
    tick();
    // 15 locked cycles (with an ignored soft_rst), 1 unlocked, then relock.
    mmcm_locked = 1'b1;
    for (int i = 0; i < 15; i++) begin
      soft_rst = (i == 5);
      tick();
    end
    soft_rst = 1'b0;
    mmcm_locked = 1'b0;
    tick();
    mmcm_locked = 1'b1;
    tstart = cyc;
    wait_sig(0, 2, 40, t);   chk("relock_align_time", t, 16);
    wait_sig(4, 1, 200, t);  chk("relock_ready_time", t, 138);

    // Soft reset in RUN.
    repeat (3) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_state", int'(st0), 2);
    chk("soft_rst_cpu", int'(rcpu[0]), 1);
    chk("soft_rst_ppu", int'(rppu[0]), 1);
    chk("soft_en_ppu", int'(eppu[0]), 0);
    tick();
    chk("soft_next_state", int'(st0), 3);
    chk("soft_first_ppu", int'(eppu[0]), 1);
    chk("soft_first_cpu", int'(ecpu[0]), 1);
    chk("soft_dut1_coinc", int'(ecpu[1] & eppu[1]), 1);

    // Synchronous reset mid-PPU_RST.
    repeat (5) tick();
    chk("pre_reset_state", int'(st0), 3);
    rst_mst = 1'b0;
    tick();
    chk_reset_vals("midreset");
    rst_mst = 1'b1;
    tstart = cyc;
    wait_sig(0, 2, 40, t);  chk("restart_align_time", t, 17);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
